// File: rtl/stream_bignum_multiplier_if.sv
// rtl/stream_bignum_multiplier_if.sv - operand load / product stream handshake bundle
// The square_in signal exists only when MULT_SQUARE_EN is defined.
interface stream_bignum_multiplier_if #(
  parameter int REGISTER_SIZE = 32
);
  logic [REGISTER_SIZE-1:0] n_in;
  logic [REGISTER_SIZE-1:0] m_in;
  logic                     low_half_in;
  logic                     valid_in;
  logic                     ready_out;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     valid_out;
  logic                     ready_in;
  logic                     final_out;
`ifdef MULT_SQUARE_EN
  logic                     square_in;

  modport master (
    output n_in, m_in, low_half_in, valid_in, ready_in, square_in,
    input  ready_out, data_out, valid_out, final_out
  );
  modport slave (
    input  n_in, m_in, low_half_in, valid_in, ready_in, square_in,
    output ready_out, data_out, valid_out, final_out
  );
`else
  modport master (
    output n_in, m_in, low_half_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, final_out
  );
  modport slave (
    input  n_in, m_in, low_half_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, final_out
  );
`endif
endinterface

// File: rtl/stream_bignum_multiplier.sv
// rtl/stream_bignum_multiplier.sv - streaming schoolbook multi-precision multiplier
// Optional MULT_SQUARE_EN adds square_in (M := N). NUM_BLOCKS must be a power of two >= 2.
module stream_bignum_multiplier #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input logic                        clk_in,
  input logic                        rst_n_in,
  stream_bignum_multiplier_if.slave  bus
);
  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int R          = REGISTER_SIZE;
  localparam int NIW        = $clog2(NUM_BLOCKS);
  localparam int AIW        = $clog2(2 * NUM_BLOCKS);

  localparam logic [NIW-1:0] LD_LAST = NIW'(NUM_BLOCKS - 1);
  localparam logic [NIW:0]   I_LAST  = (NIW + 1)'(NUM_BLOCKS);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t         state_q;
  logic [R-1:0]   n_q   [NUM_BLOCKS];
  logic [R-1:0]   m_q   [NUM_BLOCKS];
  logic [R-1:0]   acc_q [2*NUM_BLOCKS];
  logic [NIW-1:0] ld_q;
  logic [NIW:0]   i_q;
  logic [NIW-1:0] j_q;
  logic [AIW-1:0] idx_q;
  logic [R-1:0]   hi_q;
  logic [1:0]     carry_q;
  logic           low_half_q;
  logic           ready_out_q;
  logic           valid_out_q;
  logic           final_out_q;
  logic [R-1:0]   data_out_q;

  logic           in_beat_d;
  logic           out_beat_d;
  logic [R-1:0]   m_load_d;
  logic           flush_d;
  logic [R-1:0]   n_sel_d;
  logic [2*R-1:0] prod_d;
  logic [AIW-1:0] acc_idx_d;
  logic [R+1:0]   sum_d;
  logic [AIW-1:0] k_last_d;

  assign in_beat_d  = bus.valid_in & ready_out_q;
  assign out_beat_d = valid_out_q & bus.ready_in;

`ifdef MULT_SQUARE_EN
  logic square_q;
  logic square_d;
  assign square_d = (state_q == IDLE) ? bus.square_in : square_q;
  assign m_load_d = square_d ? bus.n_in : bus.m_in;
`else
  assign m_load_d = bus.m_in;
`endif

  // The extra step per row (i == NUM_BLOCKS) folds the row's last high half into the accumulator.
  assign flush_d   = (i_q == I_LAST);
  assign n_sel_d   = flush_d ? '0 : n_q[i_q[NIW-1:0]];
  assign prod_d    = {{R{1'b0}}, n_sel_d} * {{R{1'b0}}, m_q[j_q]};
  assign acc_idx_d = AIW'(i_q) + AIW'(j_q);
  // Three R-bit terms plus a carry of at most 2 never exceed R+2 bits.
  assign sum_d     = {2'b00, acc_q[acc_idx_d]} + {2'b00, prod_d[R-1:0]}
                   + {2'b00, hi_q} + {{R{1'b0}}, carry_q};
  assign k_last_d  = low_half_q ? AIW'(NUM_BLOCKS - 1) : AIW'(2 * NUM_BLOCKS - 1);

  assign bus.ready_out = ready_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.final_out = final_out_q;
  assign bus.data_out  = data_out_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      ld_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      carry_q     <= '0;
      low_half_q  <= 1'b0;
      ready_out_q <= 1'b1;
      valid_out_q <= 1'b0;
      final_out_q <= 1'b0;
      data_out_q  <= '0;
`ifdef MULT_SQUARE_EN
      square_q    <= 1'b0;
`endif
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        n_q[k] <= '0;
        m_q[k] <= '0;
      end
      for (int k = 0; k < 2*NUM_BLOCKS; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_beat_d) begin
            // Low-half runs leave the upper blocks unread, so wipe everything on start.
            for (int k = 0; k < 2*NUM_BLOCKS; k++) acc_q[k] <= '0;
            n_q[0]     <= bus.n_in;
            m_q[0]     <= m_load_d;
            low_half_q <= bus.low_half_in;
`ifdef MULT_SQUARE_EN
            square_q   <= bus.square_in;
`endif
            ld_q       <= NIW'(1);
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (in_beat_d) begin
            n_q[ld_q] <= bus.n_in;
            m_q[ld_q] <= m_load_d;
            if (ld_q == LD_LAST) begin
              state_q     <= COMPUTE;
              ready_out_q <= 1'b0;
              i_q         <= '0;
              j_q         <= '0;
              hi_q        <= '0;
              carry_q     <= '0;
            end else begin
              ld_q <= ld_q + NIW'(1);
            end
          end
        end
        COMPUTE: begin
          acc_q[acc_idx_d] <= sum_d[R-1:0];
          if (flush_d) begin
            i_q     <= '0;
            hi_q    <= '0;
            carry_q <= '0;
            if (j_q == LD_LAST) begin
              state_q     <= OUTPUT;
              valid_out_q <= 1'b1;
              final_out_q <= 1'b0;
              data_out_q  <= acc_q[0];
              idx_q       <= '0;
            end else begin
              j_q <= j_q + NIW'(1);
            end
          end else begin
            hi_q    <= prod_d[2*R-1:R];
            carry_q <= sum_d[R+1:R];
            i_q     <= i_q + (NIW + 1)'(1);
          end
        end
        OUTPUT: begin
          if (out_beat_d) begin
            acc_q[idx_q] <= '0;
            if (final_out_q) begin
              state_q     <= IDLE;
              valid_out_q <= 1'b0;
              final_out_q <= 1'b0;
              data_out_q  <= '0;
              ready_out_q <= 1'b1;
            end else begin
              idx_q       <= idx_q + AIW'(1);
              data_out_q  <= acc_q[idx_q + AIW'(1)];
              final_out_q <= ((idx_q + AIW'(1)) == k_last_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_bignum_multiplier.sv
// tb/tb_stream_bignum_multiplier.sv - directed bench with arithmetic product model
module tb_stream_bignum_multiplier;
  localparam int R  = 8;
  localparam int B  = 32;
  localparam int NB = B / R;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stream_bignum_multiplier_if #(.REGISTER_SIZE(R)) bus ();

  stream_bignum_multiplier #(.REGISTER_SIZE(R), .BITS_IN_NUM(B)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         rnd_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_final;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    bus.ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every output beat against the model queue, every stall for stability.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.valid_out), 64'(1));
        chk("stall_data",  64'(bus.data_out),  64'(prev_data));
        chk("stall_final", 64'(bus.final_out), 64'(prev_final));
      end
      prev_stall = 1'b0;
      if (bus.valid_out) begin
        if (bus.ready_in) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(1), 64'(0));
          end else begin
            chk("data",  64'(bus.data_out),  64'(exp_q[0]));
            chk("final", 64'(bus.final_out), 64'(exp_q.size() == 1));
            got_q.push_back(bus.data_out);
            void'(exp_q.pop_front());
          end
        end else begin
          prev_stall = 1'b1;
          prev_data  = bus.data_out;
          prev_final = bus.final_out;
        end
      end
    end
  end

  task automatic load_op(input logic [31:0] n, input logic [31:0] m, input bit low,
                         input bit sq, input bit toggle);
    logic [31:0] mm;
    logic [63:0] p;
    int          k;
    int          w;
    mm = sq ? n : m;
    p  = {32'd0, n} * {32'd0, mm};
    k  = low ? NB : 2 * NB;
    got_q.delete();
    for (int b = 0; b < k; b++) exp_q.push_back(p[b*8 +: 8]);
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      if (toggle && b > 0) begin
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.n_in        = n[b*8 +: 8];
      bus.m_in        = m[b*8 +: 8];
      bus.low_half_in = low;
`ifdef MULT_SQUARE_EN
      bus.square_in   = sq;
`endif
      bus.valid_in    = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.ready_out && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (w >= 50) chk("load_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
    end
    bus.n_in        = 8'hA5;
    bus.m_in        = 8'h5A;
    bus.low_half_in = ~low;
    bus.valid_in    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ready_after_load", 64'(bus.ready_out), 64'(0));
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic finish_op();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.valid_out) break;
      chk("ready_busy", 64'(bus.ready_out), 64'(0));
      w++;
      if (w > 300) begin
        chk("done_timeout", 64'(0), 64'(1));
        exp_q.delete();
        break;
      end
    end
    chk("ready_idle", 64'(bus.ready_out), 64'(1));
    chk("valid_idle", 64'(bus.valid_out), 64'(0));
    chk("final_idle", 64'(bus.final_out), 64'(0));
  endtask

  task automatic check_got(input logic [63:0] lit, input int k);
    chk("got_len", 64'(got_q.size()), 64'(k));
    for (int b = 0; b < k; b++)
      if (b < got_q.size()) chk($sformatf("lit_blk%0d", b), 64'(got_q[b]), 64'(lit[b*8 +: 8]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.valid_in    = 1'b0;
    bus.n_in        = '0;
    bus.m_in        = '0;
    bus.low_half_in = 1'b0;
`ifdef MULT_SQUARE_EN
    bus.square_in   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_out), 64'(1));
    chk("rst_valid", 64'(bus.valid_out), 64'(0));
    chk("rst_final", 64'(bus.final_out), 64'(0));
    chk("rst_data",  64'(bus.data_out),  64'(0));
    rst_n = 1'b1;

    load_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    finish_op();
    check_got(64'hFFFFFFFE_00000001, 8);

    load_op(32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1);
    finish_op();
    check_got(64'h00000000_12345678, 8);

    load_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    finish_op();
    check_got(64'h00000000_00000001, 4);

    rnd_ready = 1'b1;
    load_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    finish_op();
    check_got(64'hFFFFFFFE_00000001, 8);
    load_op(32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1);
    finish_op();
    check_got(64'h00000000_12345678, 8);
    rnd_ready = 1'b0;

    load_op(32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    finish_op();
    check_got(64'h0, 8);

    load_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0);
    finish_op();

    load_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.ready_out), 64'(1));
    chk("mid_rst_valid", 64'(bus.valid_out), 64'(0));
    chk("mid_rst_final", 64'(bus.final_out), 64'(0));
    chk("mid_rst_data",  64'(bus.data_out),  64'(0));
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(bus.valid_out), 64'(0));
    end
    load_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    finish_op();
    check_got(64'hFFFFFFFE_00000001, 8);

`ifdef MULT_SQUARE_EN
    load_op(32'h00010000, 32'h000000AA, 1'b0, 1'b1, 1'b0);
    finish_op();
    check_got(64'h00000001_00000000, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
